// File: rtl/ysyx_24100029_bp_pkg.sv
// Shared definitions for the branch prediction unit: direction-counter
// encodings and the BTB entry layout.
package ysyx_24100029_bp_pkg;

  // 2-bit saturating direction counter states
  localparam logic [1:0] CTR_SNT   = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT   = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT    = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST    = 2'b11;  // strongly taken

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Tag field is sized for the smallest legal BTB (2 entries, pc[31:3]
  // padded to pc[31:2] width). Larger BTBs store their tag zero-extended,
  // so the entry layout stays independent of BTB_ENTRIES.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

endpackage

// File: rtl/ysyx_24100029_bpu_sat_ctr2.sv
// Combinational next state of a 2-bit saturating direction counter.
module ysyx_24100029_sat_ctr2
  import ysyx_24100029_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Step one state toward the resolved direction, holding at either end
  always_comb begin
    ctr_next = ctr;
    case (ctr)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
      default: ctr_next = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/ysyx_24100029_bpu.sv
// Branch prediction unit: direct-mapped BTB with a 2-bit direction counter
// per entry. Lookup is combinational off ifu_pc; training from the resolved
// branch stream lands on the next clock edge (no same-cycle bypass).
module ysyx_24100029_bpu
  import ysyx_24100029_bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ifu_pc,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        br_valid,
  input  logic        br_is_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_npc,
  input  logic        bp_clr,
  output logic [31:0] upd_cnt,
  output logic [31:0] alloc_cnt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t           r_btb [BTB_ENTRIES];
  logic [31:0]          r_upd_cnt;
  logic [31:0]          r_alloc_cnt;

  // Lookup side
  logic [IDX_W-1:0]     w_lidx;
  logic [TAG_W-1:0]     w_ltag;
  logic [TAG_MAX_W-1:0] w_ltag_ext;
  logic                 w_lhit;
  logic                 w_pred_taken;

  // Update side
  logic [IDX_W-1:0]     w_uidx;
  logic [TAG_W-1:0]     w_utag;
  logic [TAG_MAX_W-1:0] w_utag_ext;
  logic                 w_uhit;
  logic                 w_upd_en;
  logic                 w_alloc_en;
  logic [1:0]           w_ctr_next;

  // Byte offset of the resolved PC never selects an entry
  logic [1:0]           w_unused_br_pc_lsb;

  assign w_unused_br_pc_lsb = br_pc[1:0];

  assign w_lidx     = ifu_pc[2+IDX_W-1:2];
  assign w_ltag     = ifu_pc[31:2+IDX_W];
  assign w_ltag_ext = {{IDX_W{1'b0}}, w_ltag};

  assign w_uidx     = br_pc[2+IDX_W-1:2];
  assign w_utag     = br_pc[31:2+IDX_W];
  assign w_utag_ext = {{IDX_W{1'b0}}, w_utag};

  // A flush in the same cycle swallows the resolved branch entirely
  assign w_upd_en   = br_valid & ~bp_clr;
  assign w_alloc_en = w_upd_en & ~w_uhit & br_is_taken;

  // Lookup: hit and direction from the currently stored entry
  always_comb begin
    w_lhit       = r_btb[w_lidx].valid && (r_btb[w_lidx].tag == w_ltag_ext);
    w_pred_taken = w_lhit && r_btb[w_lidx].ctr[1];
    pred_taken   = w_pred_taken;
    if (w_pred_taken) begin
      pred_pc = r_btb[w_lidx].target;
    end else begin
      pred_pc = ifu_pc + 32'd4;
    end
  end

  // Update-side hit test against the entry selected by the resolved PC
  always_comb begin
    w_uhit = r_btb[w_uidx].valid && (r_btb[w_uidx].tag == w_utag_ext);
  end

  ysyx_24100029_sat_ctr2 u_sat_ctr2 (
    .ctr      (r_btb[w_uidx].ctr),
    .taken    (br_is_taken),
    .ctr_next (w_ctr_next)
  );

  // BTB storage: flush, train on hit, allocate on taken miss
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i].valid  <= 1'b0;
        r_btb[i].tag    <= {TAG_MAX_W{1'b0}};
        r_btb[i].target <= 32'h0000_0000;
        r_btb[i].ctr    <= CTR_RESET;
      end
    end else if (bp_clr) begin
      // Only validity is dropped; counters and targets are left as they were
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i].valid <= 1'b0;
      end
    end else if (br_valid) begin
      if (w_uhit) begin
        r_btb[w_uidx].ctr <= w_ctr_next;
        if (br_is_taken) begin
          r_btb[w_uidx].target <= br_npc;
        end
      end else if (br_is_taken) begin
        // Taken miss evicts whatever occupies the slot
        r_btb[w_uidx].valid  <= 1'b1;
        r_btb[w_uidx].tag    <= w_utag_ext;
        r_btb[w_uidx].target <= br_npc;
        r_btb[w_uidx].ctr    <= CTR_ALLOC;
      end
    end
  end

  // Statistics counters; free-running and wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_upd_cnt   <= 32'h0000_0000;
      r_alloc_cnt <= 32'h0000_0000;
    end else begin
      if (w_upd_en) begin
        r_upd_cnt <= r_upd_cnt + 32'd1;
      end
      if (w_alloc_en) begin
        r_alloc_cnt <= r_alloc_cnt + 32'd1;
      end
    end
  end

  assign upd_cnt   = r_upd_cnt;
  assign alloc_cnt = r_alloc_cnt;

endmodule

// File: tb/tb_ysyx_24100029_bpu.sv
// Self-checking bench for ysyx_24100029_bpu: directed scenarios plus a
// randomized run against a behavioural BTB model.
`timescale 1ns/1ps
module tb_ysyx_24100029_bpu;

  logic        clock;
  logic        reset;
  logic [31:0] ifu_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        br_valid;
  logic        br_is_taken;
  logic [31:0] br_pc;
  logic [31:0] br_npc;
  logic        bp_clr;
  logic [31:0] upd_cnt;
  logic [31:0] alloc_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 16 entries, index pc[5:2], tag pc[31:6]
  bit          m_valid  [16];
  logic [25:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  logic [31:0] m_upd;
  logic [31:0] m_alloc;

  logic [32:0] exp_l;

  ysyx_24100029_bpu dut (
    .clock       (clock),
    .reset       (reset),
    .ifu_pc      (ifu_pc),
    .pred_taken  (pred_taken),
    .pred_pc     (pred_pc),
    .br_valid    (br_valid),
    .br_is_taken (br_is_taken),
    .br_pc       (br_pc),
    .br_npc      (br_npc),
    .bp_clr      (bp_clr),
    .upd_cnt     (upd_cnt),
    .alloc_cnt   (alloc_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 26'h0;
      m_target[i] = 32'h0;
      m_ctr[i]    = 1;
    end
    m_upd   = 32'h0;
    m_alloc = 32'h0;
  endfunction

  function automatic logic [32:0] model_lookup(input logic [31:0] pc);
    int i;
    i = int'(pc[5:2]);
    if (m_valid[i] && m_tag[i] == pc[31:6] && m_ctr[i] >= 2)
      return {1'b1, m_target[i]};
    return {1'b0, pc + 32'd4};
  endfunction

  function automatic void model_update(input bit v, input bit t,
                                       input logic [31:0] pc, input logic [31:0] npc,
                                       input bit clr);
    int i;
    i = int'(pc[5:2]);
    if (clr) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (v) begin
      m_upd = m_upd + 32'd1;
      if (m_valid[i] && m_tag[i] == pc[31:6]) begin
        if (t) begin
          m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = npc;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (t) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = pc[31:6];
        m_target[i] = npc;
        m_ctr[i]    = 2;
        m_alloc     = m_alloc + 32'd1;
      end
    end
  endfunction

  task automatic set_br(input bit v, input bit t, input logic [31:0] pc,
                        input logic [31:0] npc, input bit clr);
    br_valid    = v;
    br_is_taken = t;
    br_pc       = pc;
    br_npc      = npc;
    bp_clr      = clr;
  endtask

  // Clock edge: the model trains on the same inputs the DUT sees
  task automatic tick();
    @(posedge clock);
    model_update(br_valid, br_is_taken, br_pc, br_npc, bp_clr);
    #1;
    br_valid = 1'b0;
    bp_clr   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    ifu_pc = 32'h8000_0000;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    ifu_pc = 32'h8000_0000;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0004) begin
      errors++;
      $display("FAIL reset_lookup: got taken=%0b pc=%h, expected taken=0 pc=80000004", pred_taken, pred_pc);
    end
    checks++;
    if (upd_cnt !== 32'h0 || alloc_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: got upd=%0d alloc=%0d, expected 0 0", upd_cnt, alloc_cnt);
    end
    ifu_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: got taken=%0b pc=%h, expected taken=0 pc=00000000", pred_taken, pred_pc);
    end
  endtask

  task automatic test_alloc();
    set_br(1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0);
    ifu_pc = 32'h8000_0010;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0014) begin
      errors++;
      $display("FAIL no_bypass: got taken=%0b pc=%h, expected taken=0 pc=80000014", pred_taken, pred_pc);
    end
    tick();
    ifu_pc = 32'h8000_0010;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0100) begin
      errors++;
      $display("FAIL alloc_hit: got taken=%0b pc=%h, expected taken=1 pc=80000100", pred_taken, pred_pc);
    end
    checks++;
    if (upd_cnt !== 32'd1 || alloc_cnt !== 32'd1) begin
      errors++;
      $display("FAIL alloc_counters: got upd=%0d alloc=%0d, expected 1 1", upd_cnt, alloc_cnt);
    end
  endtask

  task automatic test_saturation();
    repeat (3) begin
      set_br(1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0);
      tick();
    end
    set_br(1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0);
    tick();
    ifu_pc = 32'h8000_0010;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0100) begin
      errors++;
      $display("FAIL sat_st_to_wt: got taken=%0b pc=%h, expected taken=1 pc=80000100", pred_taken, pred_pc);
    end
    set_br(1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0);
    tick();
    ifu_pc = 32'h8000_0010;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0014) begin
      errors++;
      $display("FAIL sat_wt_to_wnt: got taken=%0b pc=%h, expected taken=0 pc=80000014", pred_taken, pred_pc);
    end
    repeat (3) begin
      set_br(1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0);
      tick();
    end
    // From strongly-not-taken, one taken only reaches weakly-not-taken
    set_br(1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0);
    tick();
    ifu_pc = 32'h8000_0010;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0014) begin
      errors++;
      $display("FAIL sat_floor: got taken=%0b pc=%h, expected taken=0 pc=80000014", pred_taken, pred_pc);
    end
    set_br(1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0);
    tick();
    ifu_pc = 32'h8000_0010;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0100) begin
      errors++;
      $display("FAIL sat_recover: got taken=%0b pc=%h, expected taken=1 pc=80000100", pred_taken, pred_pc);
    end
    checks++;
    if (upd_cnt !== 32'd11 || alloc_cnt !== 32'd1) begin
      errors++;
      $display("FAIL sat_counters: got upd=%0d alloc=%0d, expected 11 1", upd_cnt, alloc_cnt);
    end
  endtask

  task automatic test_alias();
    set_br(1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0);
    tick();
    set_br(1'b1, 1'b1, 32'h8000_0050, 32'h8000_0500, 1'b0);
    tick();
    ifu_pc = 32'h8000_0010;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0014) begin
      errors++;
      $display("FAIL alias_evicted: got taken=%0b pc=%h, expected taken=0 pc=80000014", pred_taken, pred_pc);
    end
    ifu_pc = 32'h8000_0050;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0500) begin
      errors++;
      $display("FAIL alias_new: got taken=%0b pc=%h, expected taken=1 pc=80000500", pred_taken, pred_pc);
    end
    set_br(1'b1, 1'b0, 32'h8000_0090, 32'h0, 1'b0);
    tick();
    ifu_pc = 32'h8000_0050;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0500) begin
      errors++;
      $display("FAIL nt_miss_keeps: got taken=%0b pc=%h, expected taken=1 pc=80000500", pred_taken, pred_pc);
    end
    checks++;
    if (upd_cnt !== 32'd14 || alloc_cnt !== 32'd2) begin
      errors++;
      $display("FAIL alias_counters: got upd=%0d alloc=%0d, expected 14 2", upd_cnt, alloc_cnt);
    end
  endtask

  task automatic test_clr();
    set_br(1'b1, 1'b1, 32'h8000_0200, 32'h8000_0800, 1'b1);
    tick();
    ifu_pc = 32'h8000_0050;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0054) begin
      errors++;
      $display("FAIL clr_old: got taken=%0b pc=%h, expected taken=0 pc=80000054", pred_taken, pred_pc);
    end
    ifu_pc = 32'h8000_0200;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0204) begin
      errors++;
      $display("FAIL clr_dropped: got taken=%0b pc=%h, expected taken=0 pc=80000204", pred_taken, pred_pc);
    end
    checks++;
    if (upd_cnt !== 32'd14 || alloc_cnt !== 32'd2) begin
      errors++;
      $display("FAIL clr_counters: got upd=%0d alloc=%0d, expected 14 2", upd_cnt, alloc_cnt);
    end
    set_br(1'b1, 1'b1, 32'h8000_0200, 32'h8000_0800, 1'b0);
    tick();
    ifu_pc = 32'h8000_0200;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0800) begin
      errors++;
      $display("FAIL clr_realloc: got taken=%0b pc=%h, expected taken=1 pc=80000800", pred_taken, pred_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      pc = 32'h8000_0000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      set_br($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pc,
             $urandom & 32'hFFFF_FFFC, $urandom_range(0, 31) == 0);
      ifu_pc = 32'h8000_0000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      #1;
      exp_l = model_lookup(ifu_pc);
      checks++;
      if ({pred_taken, pred_pc} !== exp_l) begin
        errors++;
        $display("FAIL rand_lookup[%0d]: pc=%h got taken=%0b pc=%h, expected taken=%0b pc=%h",
                 n, ifu_pc, pred_taken, pred_pc, exp_l[32], exp_l[31:0]);
      end
      tick();
      checks++;
      if (upd_cnt !== m_upd || alloc_cnt !== m_alloc) begin
        errors++;
        $display("FAIL rand_counters[%0d]: got upd=%0d alloc=%0d, expected %0d %0d",
                 n, upd_cnt, alloc_cnt, m_upd, m_alloc);
      end
    end
  endtask

  task automatic test_async_reset();
    set_br(1'b1, 1'b1, 32'h8000_0040, 32'h8000_0ABC, 1'b0);
    tick();
    ifu_pc = 32'h8000_0040;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0ABC) begin
      errors++;
      $display("FAIL pre_areset: got taken=%0b pc=%h, expected taken=1 pc=80000abc", pred_taken, pred_pc);
    end
    // Mid-cycle: reset must act without waiting for the next edge
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0044) begin
      errors++;
      $display("FAIL areset_lookup: got taken=%0b pc=%h, expected taken=0 pc=80000044", pred_taken, pred_pc);
    end
    checks++;
    if (upd_cnt !== 32'h0 || alloc_cnt !== 32'h0) begin
      errors++;
      $display("FAIL areset_counters: got upd=%0d alloc=%0d, expected 0 0", upd_cnt, alloc_cnt);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    ifu_pc = 32'h8000_0040;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0044) begin
      errors++;
      $display("FAIL post_areset: got taken=%0b pc=%h, expected taken=0 pc=80000044", pred_taken, pred_pc);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_clr();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
